// File: rtl/uart_hex_pkg.sv
// Shared definitions for the UART hex sender/capture path: FSM states, ASCII codes,
// default payload width.
package uart_hex_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSend,
    StGap,
    StTerm,
    StFin
  } hex_state_e;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_A  = 8'h41;

  localparam int unsigned HEX_DATA_W = 66;

endpackage

// File: rtl/nibble_to_ascii.sv
// Combinational 4-bit to uppercase ASCII hex character encoder.
module nibble_to_ascii
  import uart_hex_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] ascii
);

  always_comb begin
    ascii = ASCII_0;
    if (nibble < 4'd10) begin
      ascii = ASCII_0 + {4'h0, nibble};
    end else begin
      ascii = ASCII_A + {4'h0, nibble} - 8'd10;
    end
  end

endmodule

// File: rtl/uart_hex_sender.sv
// Sends a latched word MSB-first as uppercase ASCII hex into the UART TX FIFO.
// Define UART_HEX_CRLF_EN to append CR LF to every frame.
module uart_hex_sender
  import uart_hex_pkg::*;
#(
  parameter int unsigned DATA_W = HEX_DATA_W
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              start,
  input  logic [DATA_W-1:0] data_in,
  input  logic              tx_full,
  output logic              write_uart,
  output logic [7:0]        write_data,
  output logic              busy,
  output logic              done
);

  localparam int unsigned NUM_DIGITS = (DATA_W + 3) / 4;
  localparam int unsigned SHIFT_W    = 4 * NUM_DIGITS;
  localparam int unsigned CNT_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_DIGITS - 1);

  hex_state_e         state_q, state_d;
  logic [SHIFT_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               wr_q, wr_d;
  logic [7:0]         wdata_q, wdata_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [7:0]         hex_char;

`ifdef UART_HEX_CRLF_EN
  // in_term: GAP belongs to the CR/LF tail; crlf_sel: 0 = CR next, 1 = LF next
  logic in_term_q, in_term_d;
  logic crlf_sel_q, crlf_sel_d;
`endif

  nibble_to_ascii u_enc (
    .nibble (shreg_q[SHIFT_W-1 -: 4]),
    .ascii  (hex_char)
  );

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    wr_d    = 1'b0;
    wdata_d = wdata_q;
    done_d  = 1'b0;
    busy_d  = (state_q != StIdle);
`ifdef UART_HEX_CRLF_EN
    in_term_d  = in_term_q;
    crlf_sel_d = crlf_sel_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (start) begin
          shreg_d = SHIFT_W'(data_in);
          cnt_d   = LAST_CNT;
          state_d = StSend;
`ifdef UART_HEX_CRLF_EN
          in_term_d  = 1'b0;
          crlf_sel_d = 1'b0;
`endif
        end
      end

      StSend: begin
        if (!tx_full) begin
          wr_d    = 1'b1;
          wdata_d = hex_char;
          state_d = StGap;
        end
      end

      StGap: begin
`ifdef UART_HEX_CRLF_EN
        if (in_term_q) begin
          if (!crlf_sel_q) begin
            crlf_sel_d = 1'b1;
            state_d    = StTerm;
          end else begin
            state_d = StFin;
          end
        end else begin
          shreg_d = shreg_q << 4;
          if (cnt_q == '0) begin
            in_term_d  = 1'b1;
            crlf_sel_d = 1'b0;
            state_d    = StTerm;
          end else begin
            cnt_d   = cnt_q - 1'b1;
            state_d = StSend;
          end
        end
`else
        shreg_d = shreg_q << 4;
        if (cnt_q == '0) begin
          state_d = StFin;
        end else begin
          cnt_d   = cnt_q - 1'b1;
          state_d = StSend;
        end
`endif
      end

`ifdef UART_HEX_CRLF_EN
      StTerm: begin
        if (!tx_full) begin
          wr_d    = 1'b1;
          wdata_d = crlf_sel_q ? ASCII_LF : ASCII_CR;
          state_d = StGap;
        end
      end
`endif

      StFin: begin
        done_d  = 1'b1;
        state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= StIdle;
      shreg_q <= '0;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      wdata_q <= 8'h00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef UART_HEX_CRLF_EN
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      in_term_q  <= 1'b0;
      crlf_sel_q <= 1'b0;
    end else begin
      in_term_q  <= in_term_d;
      crlf_sel_q <= crlf_sel_d;
    end
  end
`endif

  assign write_uart = wr_q;
  assign write_data = wdata_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_uart_hex_sender.sv
// Directed bench for uart_hex_sender with a character scoreboard and edge-timing checks.
module tb_uart_hex_sender;

  localparam int unsigned DATA_W = 66;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [DATA_W-1:0] data_in;
  logic              tx_full;
  logic              write_uart;
  logic [7:0]        write_data;
  logic              busy;
  logic              done;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];

  uart_hex_sender #(.DATA_W(DATA_W)) dut (
    .CLK        (clk),
    .RST_N      (rst_n),
    .start      (start),
    .data_in    (data_in),
    .tx_full    (tx_full),
    .write_uart (write_uart),
    .write_data (write_data),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] hex_char(input logic [3:0] nib);
    return (nib < 4'd10) ? (8'h30 + 8'(nib)) : (8'h37 + 8'(nib));
  endfunction

  // s_idx/s_len: stall before char s_idx for s_len cycles; xs_edge: extra start at that edge
  // (-1 = during FIN); abort_k: assert reset right after the abort_k-th write.
  task automatic send_frame(input logic [DATA_W-1:0] d, input int s_idx, input int s_len,
                            input int xs_edge, input int abort_k);
    logic [67:0] ext;
    int nw, wr_n, e, done_e, exp_t, xs;
    logic prev_wr;
    bit fin;
    ext = 68'(d);
    for (int k = 0; k < 17; k++) exp_q.push_back(hex_char(ext[4*(16-k) +: 4]));
`ifdef UART_HEX_CRLF_EN
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
    nw = 19;
`else
    nw = 17;
`endif
    done_e = 2 * nw + 1 + s_len;
    xs = (xs_edge < 0) ? done_e : xs_edge;
    data_in = d;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_edge0", 64'(busy), 64'(0));
    check("wr_edge0", 64'(write_uart), 64'(0));
    wr_n = 0; prev_wr = 1'b0; fin = 1'b0; e = 0;
    while (!fin) begin
      if (s_len > 0 && e == 2 * s_idx) tx_full = 1'b1;
      if (s_len > 0 && e == 2 * s_idx + s_len) tx_full = 1'b0;
      if (xs > 0 && e == xs - 1) begin start = 1'b1; data_in = ~d; end
      if (xs > 0 && e == xs) start = 1'b0;
      @(posedge clk); #1;
      e++;
      if (e == 1) check("busy_rise", 64'(busy), 64'(1));
      if (write_uart) begin
        exp_t = 2 * wr_n + 1 + ((s_len > 0 && wr_n >= s_idx) ? s_len : 0);
        check("wr_edge", 64'(e), 64'(exp_t));
        check("wr_back_to_back", 64'(prev_wr), 64'(0));
        if (exp_q.size() == 0) check("wr_extra", 64'(1), 64'(0));
        else check("wr_char", 64'(write_data), 64'(exp_q.pop_front()));
        wr_n++;
        if (abort_k > 0 && wr_n == abort_k) begin
          rst_n = 1'b0;
          #1;
          check("rst_wr", 64'(write_uart), 64'(0));
          check("rst_data", 64'(write_data), 64'(0));
          check("rst_busy", 64'(busy), 64'(0));
          check("rst_done", 64'(done), 64'(0));
          repeat (3) begin
            @(posedge clk); #1;
            check("rst_hold_wr", 64'(write_uart), 64'(0));
          end
          rst_n = 1'b1;
          exp_q.delete();
          fin = 1'b1;
        end
      end
      prev_wr = write_uart;
      if (!fin && done) begin
        check("done_edge", 64'(e), 64'(done_e));
        check("done_writes", 64'(wr_n), 64'(nw));
        check("busy_at_done", 64'(busy), 64'(1));
        fin = 1'b1;
      end
      if (!fin && e > done_e + 5) begin
        check("timeout_done", 64'(e), 64'(done_e));
        fin = 1'b1;
      end
    end
    start = 1'b0;
    tx_full = 1'b0;
    if (abort_k == 0) begin
      @(posedge clk); #1;
      check("busy_fall", 64'(busy), 64'(0));
      repeat (6) begin
        @(posedge clk); #1;
        check("idle_wr", 64'(write_uart), 64'(0));
        check("idle_done", 64'(done), 64'(0));
      end
      check("queue_empty", 64'(exp_q.size()), 64'(0));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    tx_full = 1'b0;
    data_in = '0;
    #1;
    check("reset_wr", 64'(write_uart), 64'(0));
    check("reset_data", 64'(write_data), 64'(0));
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_done", 64'(done), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    send_frame(66'h3_0123_4567_89AB_CDEF, 0, 0, 0, 0);
    send_frame('0, 0, 0, 0, 0);
    send_frame({DATA_W{1'b1}}, 0, 0, 0, 0);
    send_frame(66'h2_FEDC_BA98_7654_3210, 3, 5, 0, 0);
    send_frame(66'h1_A5A5_5A5A_0F0F_F0F0, 0, 0, 10, 0);
    send_frame(66'h0_1357_9BDF_2468_ACE0, 0, 0, -1, 0);
    send_frame(66'h3_0123_4567_89AB_CDEF, 0, 0, 0, 8);
    @(posedge clk); #1;
    send_frame(66'h2_DEAD_BEEF_CAFE_F00D, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
